uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rr_pick.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart blocks: arbiter state encoding and limits.
package uart_pkg;

  typedef enum logic {
    UART_ARB_IDLE = 1'b0,
    UART_ARB_LOCK = 1'b1
  } uart_arb_state_e;

  localparam int UART_ARB_MIN_REQ = 2;
  localparam int UART_ARB_MAX_REQ = 8;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin priority search: first asserted request at or after ptr, wrapping.
module uart_rr_pick #(
  parameter int P_REQ_NUM = 4,
  parameter int P_PTR_W   = $clog2(P_REQ_NUM)
) (
  input  logic [P_REQ_NUM-1:0] req,
  input  logic [P_PTR_W-1:0]   ptr,
  output logic [P_REQ_NUM-1:0] grant
);

  logic found;
  int   idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < P_REQ_NUM; i++) begin
      idx = (int'(ptr) + i) % P_REQ_NUM;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-locking round-robin arbiter that funnels several byte streams into one
// uart_drive TX user interface, with an optional idle timeout on the held grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int P_REQ_NUM         = 4,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_LOCK_TIMEOUT    = 1024
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [P_REQ_NUM-1:0]                   i_req_valid,
  input  logic [P_REQ_NUM*P_UART_DATA_WIDTH-1:0] i_req_data,
  input  logic [P_REQ_NUM-1:0]                   i_req_last,
  output logic [P_REQ_NUM-1:0]                   o_req_ready,
  output logic [P_UART_DATA_WIDTH-1:0]           o_tx_data,
  output logic                                   o_tx_valid,
  input  logic                                   i_tx_ready,
  output logic [P_REQ_NUM-1:0]                   o_grant,
  output logic                                   o_busy,
  output logic                                   o_timeout
);

  localparam int PTR_W = $clog2(P_REQ_NUM);
  localparam int CNT_W = (P_LOCK_TIMEOUT > 0) ? $clog2(P_LOCK_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(P_LOCK_TIMEOUT);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(P_REQ_NUM - 1);

  function automatic logic [PTR_W-1:0] onehot_idx(input logic [P_REQ_NUM-1:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < P_REQ_NUM; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

  uart_arb_state_e        state, state_nxt;
  logic [P_REQ_NUM-1:0]   grant, grant_nxt;
  logic [PTR_W-1:0]       owner, owner_nxt;
  logic [PTR_W-1:0]       rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0]       idle_cnt, idle_cnt_nxt;
  logic                   timeout_q, timeout_nxt;

  logic [P_REQ_NUM-1:0]         pick_grant;
  logic [PTR_W-1:0]             ptr_after;
  logic [P_UART_DATA_WIDTH-1:0] owner_data;
  logic                         lock, any_req, owner_valid, owner_last;
  logic                         xfer, release_last, timeout_hit;

  uart_rr_pick #(
    .P_REQ_NUM (P_REQ_NUM),
    .P_PTR_W   (PTR_W)
  ) u_rr_pick (
    .req   (i_req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant)
  );

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < P_REQ_NUM; i++) begin
      if (grant[i]) owner_data = owner_data | i_req_data[i*P_UART_DATA_WIDTH +: P_UART_DATA_WIDTH];
    end
  end

  assign lock         = (state == UART_ARB_LOCK);
  assign any_req      = |i_req_valid;
  assign owner_valid  = |(i_req_valid & grant);
  assign owner_last   = |(i_req_last & grant);
  assign xfer         = lock && owner_valid && i_tx_ready;
  assign release_last = xfer && owner_last;
  // A transfer in the same cycle as the limit always wins over the timeout.
  assign timeout_hit  = lock && (P_LOCK_TIMEOUT != 0) && (idle_cnt == CNT_LIMIT) && !xfer;
  assign ptr_after    = (owner == PTR_LAST) ? '0 : owner + PTR_W'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= UART_ARB_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      UART_ARB_IDLE: if (any_req) state_nxt = UART_ARB_LOCK;
      UART_ARB_LOCK: if (release_last || timeout_hit) state_nxt = UART_ARB_IDLE;
      default:       state_nxt = UART_ARB_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = lock;
    o_tx_valid  = lock && owner_valid;
    o_tx_data   = lock ? owner_data : '0;
    o_req_ready = lock ? (grant & {P_REQ_NUM{i_tx_ready}}) : '0;
  end

  // Grant, pointer and idle-counter updates that accompany the state transitions.
  always_comb begin
    grant_nxt    = grant;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    idle_cnt_nxt = idle_cnt;
    timeout_nxt  = 1'b0;
    case (state)
      UART_ARB_IDLE: begin
        if (any_req) begin
          grant_nxt    = pick_grant;
          owner_nxt    = onehot_idx(pick_grant);
          idle_cnt_nxt = '0;
        end
      end
      UART_ARB_LOCK: begin
        if (release_last || timeout_hit) begin
          grant_nxt    = '0;
          rr_ptr_nxt   = ptr_after;
          idle_cnt_nxt = '0;
          timeout_nxt  = timeout_hit;
        end else if (xfer) begin
          idle_cnt_nxt = '0;
        end else if (!owner_valid && (idle_cnt != CNT_LIMIT)) begin
          idle_cnt_nxt = idle_cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      grant     <= grant_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      idle_cnt  <= idle_cnt_nxt;
      timeout_q <= timeout_nxt;
    end
  end

  assign o_grant   = grant;
  assign o_timeout = timeout_q;

endmodule
